move_controller: RTL and testbench
==================================

# move_controller

Sequences a single Connect Four drop request from the game control logic. The block owns the 7-column × 6-row board state. It fetches the addressed column and presents it to the move validator. It then commits the validator's updated column, or rejects the move. It also tracks whose turn it is and how many moves have been played, and exports the whole board to the display and win-check logic.

## Interface

Parameters:
- NUM_COLS, 7, number of columns; column index width is 3 bits.
- NUM_ROWS, 6, cells per column; fixed to match the validator's 6-bit column words.

Ports:
- clk  input  1  sole clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- go  input  1  drop request; sampled only in IDLE.
- column  input  3  target column 0–6, sampled with go.
- onoff_data  output  6  registered occupancy word of the fetched column, to the validator.
- player_data  output  6  registered owner word of the fetched column, to the validator.
- cur_player  output  1  player to move: 0 or 1. Also drives the validator.
- valid_move  input  1  validator result: the column is not full.
- write_onoff  input  6  validator's next occupancy word.
- write_player  input  6  validator's next owner word.
- busy  output  1  high in every state except IDLE.
- move_done  output  1  one-cycle pulse when a move is committed.
- move_invalid  output  1  one-cycle pulse when a move is rejected.
- board_onoff  output  42  occupancy of all columns; column c is at bits [6c+5:6c], bit 0 is the bottom row.
- board_player  output  42  owners of all columns, same layout as board_onoff.
- move_count  output  6  committed moves, range 0–42.
- board_full  output  1  high when move_count == 42.

## Operation

- State machine, Moore outputs:
  - IDLE, FETCH, CHECK, COMMIT, REJECT.
- IDLE:
  - go=1 → capture column into col_q, go to FETCH.
  - go=0 → stay in IDLE.
- FETCH:
  - Load onoff_data and player_data from column col_q.
  - If col_q > 6, load both words as 0.
  - Next state: CHECK.
- CHECK:
  - Latch write_onoff and write_player into staging registers.
  - valid_move=1 and col_q ≤ 6 → COMMIT; otherwise → REJECT.
- COMMIT:
  - move_done=1.
  - On exit: write the staged words into column col_q, toggle cur_player, increment move_count.
  - Next state: IDLE.
- REJECT:
  - move_invalid=1.
  - No change to the board, cur_player or move_count.
  - Next state: IDLE.
- Board semantics:
  - Occupancy fills from bit 0 upward.
  - A player_data bit is meaningful only where the matching onoff bit is 1; a 1 marks player 1.
  - A column is full when its occupancy word is 6'b111111.
- go while busy is ignored. It is not queued.
- Column index 7 always yields REJECT, whatever valid_move says.
- move_count saturates at 42. Once the board is full every column is full, so every further move is rejected.
- cur_player and move_count change only on a commit.

## Timing

- Let edge k be the edge that samples go=1 in IDLE.
  - Edge k+1: onoff_data and player_data become valid.
  - Edge k+2: validator outputs are latched.
  - Cycle after edge k+2: move_done or move_invalid is high for exactly one cycle.
  - Edge k+3: board, cur_player and move_count update; state returns to IDLE.
- Next acceptable go: sampled at edge k+4 at the earliest.
- Latency from request to pulse: 3 cycles. Throughput: one move per 4 cycles.
- The validator is combinational. Its outputs must settle within the CHECK cycle.
- Reset values:
  - state IDLE; col_q 0.
  - onoff_data and player_data 0; staging registers 0.
  - board_onoff and board_player all 0.
  - cur_player 0; move_count 0.
  - busy, move_done, move_invalid and board_full 0.
- Reset takes priority in any state. Reset during FETCH, CHECK or COMMIT aborts the move with no board write and no pulse on the following cycle.
- reset and go together: reset wins and go is dropped.

## Test plan

- Reset, then go with column=3. Then:
  - move_done pulses at the 3-cycle latency.
  - board_onoff[23:18] = 000001 and board_player[23:18] = 000000.
  - cur_player = 1 and move_count = 1.
- Second go on column 3 → column bits become onoff 000011, player 000010; cur_player = 0; move_count = 2.
- Six drops into column 0, then a seventh → the seventh gives a move_invalid pulse, and column 0, cur_player and move_count (6) are unchanged.
- go with column=7 → move_invalid pulses even when the validator is forced to valid_move=1; nothing else changes.
- go held high continuously → exactly one move per 4 cycles; go pulses during busy produce no extra moves.
- Reset asserted in the CHECK cycle → no pulse, board stays all zero, state is IDLE on the next cycle.
- Fill all 42 cells → board_full = 1 and move_count = 42; any further go → move_invalid.

Source files
------------

// File: rtl/move_controller_if.sv
// Signal bundle between the move controller, the game control logic,
// the combinational move validator and the display/win-check logic.
interface move_controller_if;
  // request side (game control logic)
  logic        go;
  logic [2:0]  column;
  logic        busy;
  logic        move_done;
  logic        move_invalid;

  // validator side
  logic [5:0]  onoff_data;
  logic [5:0]  player_data;
  logic        cur_player;
  logic        valid_move;
  logic [5:0]  write_onoff;
  logic [5:0]  write_player;

  // board export
  logic [41:0] board_onoff;
  logic [41:0] board_player;
  logic [5:0]  move_count;
  logic        board_full;

  // the controller itself
  modport slave (
    input  go, column, valid_move, write_onoff, write_player,
    output busy, move_done, move_invalid, onoff_data, player_data,
           cur_player, board_onoff, board_player, move_count, board_full
  );

  // everything around the controller (game logic, validator, display)
  modport master (
    output go, column, valid_move, write_onoff, write_player,
    input  busy, move_done, move_invalid, onoff_data, player_data,
           cur_player, board_onoff, board_player, move_count, board_full
  );
endinterface

// File: rtl/move_controller.sv
// Connect Four move sequencer: owns the 7x6 board, fetches the requested
// column for the external validator, then commits the validator's updated
// column or rejects the move. Tracks the player to move and the move count.
module move_controller #(
  parameter int NUM_COLS = 7,
  parameter int NUM_ROWS = 6
) (
  input  logic              clk,
  input  logic              reset,
  move_controller_if.slave  bus
);

  localparam int COL_W = 3;
  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] MAX_MOVES = CNT_W'(NUM_COLS * NUM_ROWS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CHECK,
    S_COMMIT,
    S_REJECT
  } state_t;

  state_t                    state_q, state_d;
  logic [COL_W-1:0]          col_q;
  logic                      col_ok;

  logic [NUM_ROWS-1:0]       onoff_data_q, player_data_q;
  logic [NUM_ROWS-1:0]       stage_onoff_q, stage_player_q;
  logic [NUM_ROWS-1:0]       fetch_onoff, fetch_player;

  logic [NUM_COLS*NUM_ROWS-1:0] board_onoff_w, board_player_w;

  logic                      cur_player_q;
  logic [CNT_W-1:0]          move_count_q;

  logic                      busy_s, move_done_s, move_invalid_s;
  logic                      commit_en;

  // An out-of-range column (only index 7 with 3 bits) is never committed.
  assign col_ok    = ({1'b0, col_q} < (COL_W + 1)'(NUM_COLS));
  assign commit_en = (state_q == S_COMMIT);

  // State register; reset aborts any move in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and Moore status outputs.
  always_comb begin
    state_d        = state_q;
    busy_s         = 1'b1;
    move_done_s    = 1'b0;
    move_invalid_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_s = 1'b0;
        if (bus.go) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        // validator is combinational on the fetched words, so its verdict
        // is settled by the end of this cycle
        state_d = (bus.valid_move && col_ok) ? S_COMMIT : S_REJECT;
      end
      S_COMMIT: begin
        move_done_s = 1'b1;
        state_d     = S_IDLE;
      end
      S_REJECT: begin
        move_invalid_s = 1'b1;
        state_d        = S_IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Capture the requested column; go is only honoured while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q <= '0;
    end else if (state_q == S_IDLE && bus.go) begin
      col_q <= bus.column;
    end
  end

  // Column select for the fetch; unmatched index reads as empty.
  always_comb begin
    fetch_onoff  = '0;
    fetch_player = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (col_q == COL_W'(c)) begin
        fetch_onoff  = board_onoff_w[c*NUM_ROWS +: NUM_ROWS];
        fetch_player = board_player_w[c*NUM_ROWS +: NUM_ROWS];
      end
    end
  end

  // Registered column words presented to the validator.
  always_ff @(posedge clk) begin
    if (reset) begin
      onoff_data_q  <= '0;
      player_data_q <= '0;
    end else if (state_q == S_FETCH) begin
      onoff_data_q  <= fetch_onoff;
      player_data_q <= fetch_player;
    end
  end

  // Staging registers hold the validator's proposed column until commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_onoff_q  <= '0;
      stage_player_q <= '0;
    end else if (state_q == S_CHECK) begin
      stage_onoff_q  <= bus.write_onoff;
      stage_player_q <= bus.write_player;
    end
  end

  // One register pair per column; written only on leaving COMMIT.
  generate
    for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col
      logic [NUM_ROWS-1:0] onoff_q;
      logic [NUM_ROWS-1:0] player_q;

      // Column storage update on commit to this column.
      always_ff @(posedge clk) begin
        if (reset) begin
          onoff_q  <= '0;
          player_q <= '0;
        end else if (commit_en && col_q == COL_W'(gi)) begin
          onoff_q  <= stage_onoff_q;
          player_q <= stage_player_q;
        end
      end

      assign board_onoff_w[gi*NUM_ROWS +: NUM_ROWS]  = onoff_q;
      assign board_player_w[gi*NUM_ROWS +: NUM_ROWS] = player_q;
    end
  endgenerate

  // Turn and move counter advance only on a committed move.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_player_q <= 1'b0;
      move_count_q <= '0;
    end else if (commit_en) begin
      cur_player_q <= ~cur_player_q;
      if (move_count_q != MAX_MOVES) begin
        move_count_q <= move_count_q + 1'b1;
      end
    end
  end

  assign bus.busy         = busy_s;
  assign bus.move_done    = move_done_s;
  assign bus.move_invalid = move_invalid_s;
  assign bus.onoff_data   = onoff_data_q;
  assign bus.player_data  = player_data_q;
  assign bus.cur_player   = cur_player_q;
  assign bus.board_onoff  = board_onoff_w;
  assign bus.board_player = board_player_w;
  assign bus.move_count   = move_count_q;
  assign bus.board_full   = (move_count_q == MAX_MOVES);

endmodule

// File: tb/tb_move_controller.sv
// Directed bench for move_controller: a vector table of single moves plus
// hand-written sequences for held go, mid-move reset and a full board.
module tb_move_controller;

  logic clk;
  logic reset;
  logic force_valid;

  move_controller_if bus();

  move_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational validator: drop lands on the lowest empty row.
  always_comb begin
    logic [5:0] nxt;
    nxt              = {bus.onoff_data[4:0], 1'b1};
    bus.valid_move   = force_valid | ~bus.onoff_data[5];
    bus.write_onoff  = nxt;
    bus.write_player = bus.player_data |
                       (bus.cur_player ? (nxt & ~bus.onoff_data) : 6'b0);
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.go = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One request; samples pulses at the exact latency and checks busy timing.
  task automatic run_move(input logic [2:0] col, input bit fv,
                          output bit got_done, output bit got_inv);
    @(negedge clk);
    force_valid = fv;
    bus.go      = 1'b1;
    bus.column  = col;
    @(negedge clk);                 // after edge k: FETCH
    bus.go = 1'b0;
    check("busy_fetch", bus.busy, 1'b1);
    check("no_early_pulse", {bus.move_done, bus.move_invalid}, 2'b00);
    @(negedge clk);                 // after edge k+1: CHECK
    check("no_pulse_check", {bus.move_done, bus.move_invalid}, 2'b00);
    @(negedge clk);                 // after edge k+2: COMMIT or REJECT
    got_done = bus.move_done;
    got_inv  = bus.move_invalid;
    @(negedge clk);                 // after edge k+3: IDLE, state updated
    check("pulse_one_cycle", {bus.move_done, bus.move_invalid}, 2'b00);
    check("idle_after", bus.busy, 1'b0);
    force_valid = 1'b0;
    $display("move col=%0d force=%0d done=%0d invalid=%0d player=%0d count=%0d",
             col, fv, got_done, got_inv, bus.cur_player, bus.move_count);
  endtask

  typedef struct {
    bit         rst_first;
    logic [2:0] col;
    bit         fv;
    bit         exp_done;
    bit         exp_inv;
    logic [2:0] chk_col;
    logic [5:0] exp_on;
    logic [5:0] exp_pl;
    bit         exp_cur;
    logic [5:0] exp_cnt;
  } vec_t;

  vec_t vecs[12];

  initial begin
    bit d, iv;
    int n_done, n_inv;
    logic [41:0] all_ones;
    logic [41:0] full_player;

    // rst, col, fv, done, inv, chk, onoff, player, cur, cnt
    vecs[0]  = '{1, 3'd3, 0, 1, 0, 3'd3, 6'b000001, 6'b000000, 1, 6'd1};
    vecs[1]  = '{0, 3'd3, 0, 1, 0, 3'd3, 6'b000011, 6'b000010, 0, 6'd2};
    vecs[2]  = '{1, 3'd0, 0, 1, 0, 3'd0, 6'b000001, 6'b000000, 1, 6'd1};
    vecs[3]  = '{0, 3'd0, 0, 1, 0, 3'd0, 6'b000011, 6'b000010, 0, 6'd2};
    vecs[4]  = '{0, 3'd0, 0, 1, 0, 3'd0, 6'b000111, 6'b000010, 1, 6'd3};
    vecs[5]  = '{0, 3'd0, 0, 1, 0, 3'd0, 6'b001111, 6'b001010, 0, 6'd4};
    vecs[6]  = '{0, 3'd0, 0, 1, 0, 3'd0, 6'b011111, 6'b001010, 1, 6'd5};
    vecs[7]  = '{0, 3'd0, 0, 1, 0, 3'd0, 6'b111111, 6'b101010, 0, 6'd6};
    vecs[8]  = '{0, 3'd0, 0, 0, 1, 3'd0, 6'b111111, 6'b101010, 0, 6'd6};
    vecs[9]  = '{0, 3'd7, 1, 0, 1, 3'd0, 6'b111111, 6'b101010, 0, 6'd6};
    vecs[10] = '{0, 3'd6, 0, 1, 0, 3'd6, 6'b000001, 6'b000000, 1, 6'd7};
    vecs[11] = '{0, 3'd7, 0, 0, 1, 3'd6, 6'b000001, 6'b000000, 1, 6'd7};

    reset       = 1'b1;
    force_valid = 1'b0;
    bus.go      = 1'b0;
    bus.column  = 3'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // reset state
    check("rst_busy", bus.busy, 1'b0);
    check("rst_pulses", {bus.move_done, bus.move_invalid}, 2'b00);
    check("rst_board_onoff", bus.board_onoff, 42'd0);
    check("rst_board_player", bus.board_player, 42'd0);
    check("rst_cur_player", bus.cur_player, 1'b0);
    check("rst_move_count", bus.move_count, 6'd0);
    check("rst_board_full", bus.board_full, 1'b0);
    check("rst_data", {bus.onoff_data, bus.player_data}, 12'd0);

    // table of single moves
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].rst_first) do_reset();
      run_move(vecs[i].col, vecs[i].fv, d, iv);
      check($sformatf("v%0d_done", i), d, vecs[i].exp_done);
      check($sformatf("v%0d_invalid", i), iv, vecs[i].exp_inv);
      check($sformatf("v%0d_onoff", i), bus.board_onoff[vecs[i].chk_col*6 +: 6], vecs[i].exp_on);
      check($sformatf("v%0d_player", i), bus.board_player[vecs[i].chk_col*6 +: 6], vecs[i].exp_pl);
      check($sformatf("v%0d_cur", i), bus.cur_player, vecs[i].exp_cur);
      check($sformatf("v%0d_count", i), bus.move_count, vecs[i].exp_cnt);
    end

    // go held high: one move every 4 cycles, nothing queued while busy
    do_reset();
    @(negedge clk);
    bus.go = 1'b1;
    bus.column = 3'd2;
    n_done = 0;
    n_inv  = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (bus.move_done) begin
        n_done++;
        check($sformatf("held_pulse_slot%0d", i), i % 4, 3);
      end
      if (bus.move_invalid) n_inv++;
    end
    bus.go = 1'b0;
    repeat (4) @(negedge clk);
    $display("held go: done=%0d invalid=%0d count=%0d", n_done, n_inv, bus.move_count);
    check("held_done_count", n_done, 4);
    check("held_invalid_count", n_inv, 0);
    check("held_move_count", bus.move_count, 6'd4);
    check("held_col2_onoff", bus.board_onoff[17:12], 6'b001111);
    check("held_col2_player", bus.board_player[17:12], 6'b001010);

    // reset during CHECK aborts the move
    do_reset();
    @(negedge clk);
    bus.go = 1'b1;
    bus.column = 3'd1;
    @(negedge clk);                 // FETCH
    bus.go = 1'b0;
    @(negedge clk);                 // CHECK
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    $display("reset in CHECK: busy=%0d done=%0d invalid=%0d", bus.busy, bus.move_done, bus.move_invalid);
    check("abort_idle", bus.busy, 1'b0);
    check("abort_no_pulse", {bus.move_done, bus.move_invalid}, 2'b00);
    @(negedge clk);
    check("abort_no_pulse_later", {bus.move_done, bus.move_invalid}, 2'b00);
    check("abort_board", bus.board_onoff, 42'd0);
    check("abort_count", bus.move_count, 6'd0);

    // reset and go together: go is dropped
    @(negedge clk);
    reset = 1'b1;
    bus.go = 1'b1;
    bus.column = 3'd4;
    @(negedge clk);
    reset = 1'b0;
    bus.go = 1'b0;
    check("rstgo_idle", bus.busy, 1'b0);
    repeat (3) @(negedge clk);
    $display("reset+go: busy=%0d count=%0d", bus.busy, bus.move_count);
    check("rstgo_no_move", {bus.busy, bus.move_done, bus.move_invalid, bus.move_count}, 9'd0);

    // fill all 42 cells
    do_reset();
    n_done = 0;
    for (int c = 0; c < 7; c++) begin
      for (int r = 0; r < 6; r++) begin
        if (c == 6 && r == 5) check("pre_full_flag", bus.board_full, 1'b0);
        run_move(3'(c), 1'b0, d, iv);
        if (d) n_done++;
      end
    end
    all_ones    = '1;
    full_player = {7{6'b101010}};
    check("fill_done_count", n_done, 42);
    check("fill_board_full", bus.board_full, 1'b1);
    check("fill_move_count", bus.move_count, 6'd42);
    check("fill_onoff", bus.board_onoff, all_ones);
    check("fill_player", bus.board_player, full_player);
    run_move(3'd4, 1'b0, d, iv);
    check("full_reject_done", d, 1'b0);
    check("full_reject_invalid", iv, 1'b1);
    check("full_count_kept", bus.move_count, 6'd42);
    check("full_player_kept", bus.board_player, full_player);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

endmodule
